// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - read-side port bundle of the UART receive FIFO
`timescale 1ns/1ps
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) ();
    logic                          rd_en;
    logic [DATA_BITS-1:0]          rd_data;
    logic                          empty;
    logic                          full;
    logic [$clog2(FIFO_DEPTH):0]   count;

    modport master (output rd_en, input rd_data, input empty, input full, input count);
    modport slave  (input rd_en, output rd_data, output empty, output full, output count);
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with frame/parity/overrun flags and a show-ahead FIFO
`timescale 1ns/1ps
module uart_rx_fifo #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          rx,
    output logic          busy,
    output logic          frame_err,
    output logic          parity_err,
    output logic          overrun,
    uart_rx_fifo_if.slave rd
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = $clog2(DATA_BITS);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_BIT = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_BIT = CW'(DIV / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t               state;
    logic                 rx_meta, rxs;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bits_left;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_ok;
    logic                 wr_req;
    logic [DATA_BITS-1:0] wr_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            bits_left  <= '0;
            shreg      <= '0;
            par_ok     <= 1'b1;
            wr_req     <= 1'b0;
            wr_data    <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            wr_req     <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            case (state)
                IDLE: if (!rxs) begin
                    state <= START;
                    cnt   <= HALF_BIT;
                end
                START: if (cnt == '0) begin
                    // a start bit that is gone by mid-bit is treated as noise
                    state     <= rxs ? IDLE : DATA;
                    cnt       <= FULL_BIT;
                    bits_left <= BW'(DATA_BITS - 1);
                    par_ok    <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DATA: if (cnt == '0) begin
                    shreg <= {rxs, shreg[DATA_BITS-1:1]};
                    cnt   <= FULL_BIT;
                    if (bits_left == '0) state <= (PARITY != 0) ? PAR : STOP;
                    else                 bits_left <= bits_left - 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                PAR: if (cnt == '0) begin
                    par_ok <= (rxs == ((^shreg) ^ (PARITY == 2)));
                    state  <= STOP;
                    cnt    <= FULL_BIT;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                STOP: if (cnt == '0) begin
                    cnt <= FULL_BIT;
                    if (!rxs) begin
                        frame_err <= 1'b1;
                        state     <= BRK;
                    end else begin
                        wr_req     <= par_ok;
                        wr_data    <= shreg;
                        parity_err <= !par_ok;
                        state      <= IDLE;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                BRK: if (rxs) begin
                    state <= IDLE;
                    cnt   <= FULL_BIT;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count_q, count_nxt;
    logic                 empty_q, full_q;
    logic                 do_push, do_pop;

    // a pop frees the slot for a simultaneous push even when full
    assign do_pop  = rd.rd_en && !empty_q;
    assign do_push = wr_req && (!full_q || do_pop);

    always_comb begin
        count_nxt = count_q;
        if (do_push && !do_pop) count_nxt = count_q + 1'b1;
        if (do_pop && !do_push) count_nxt = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_nxt;
            empty_q <= (count_nxt == '0);
            full_q  <= (count_nxt == (AW+1)'(FIFO_DEPTH));
            overrun <= wr_req && full_q && !rd.rd_en;
        end
    end

    assign rd.rd_data = empty_q ? '0 : mem[rd_ptr];
    assign rd.empty   = empty_q;
    assign rd.full    = full_q;
    assign rd.count   = count_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo (8N1 and 8E1 instances)
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int DIV = 217;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rstn, rx_a, rx_b;
    logic busy_a, fe_a, pe_a, ov_a;
    logic busy_b, fe_b, pe_b, ov_b;

    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_a ();
    uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if_b ();

    uart_rx_fifo #(.CLK_HZ(25000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) dut_a (
        .clk(clk), .rstn(rstn), .rx(rx_a), .busy(busy_a), .frame_err(fe_a),
        .parity_err(pe_a), .overrun(ov_a), .rd(if_a.slave));

    uart_rx_fifo #(.CLK_HZ(25000000), .BAUD(115200), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rstn(rstn), .rx(rx_b), .busy(busy_b), .frame_err(fe_b),
        .parity_err(pe_b), .overrun(ov_b), .rd(if_b.slave));

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int fl_a[$];
    int fl_b[$];

    localparam int F_FRAME = 1, F_PAR = 2, F_OVR = 3;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_ev(input bit inst, input int code);
        if (inst == 1'b0) begin
            if (fl_a.size() == 0) check("a_flag_extra", code, 0);
            else                  check("a_flag_kind", code, fl_a.pop_front());
        end else begin
            if (fl_b.size() == 0) check("b_flag_extra", code, 0);
            else                  check("b_flag_kind", code, fl_b.pop_front());
        end
    endtask

    // monitor: every pop and every flag pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (if_a.rd_en && !if_a.empty) begin
            if (exp_a.size() == 0) check("a_pop_extra", exp_a.size(), 1);
            else                   check("a_pop_data", if_a.rd_data, exp_a.pop_front());
        end
        if (if_b.rd_en && !if_b.empty) begin
            if (exp_b.size() == 0) check("b_pop_extra", exp_b.size(), 1);
            else                   check("b_pop_data", if_b.rd_data, exp_b.pop_front());
        end
        if (fe_a) flag_ev(1'b0, F_FRAME);
        if (pe_a) flag_ev(1'b0, F_PAR);
        if (ov_a) flag_ev(1'b0, F_OVR);
        if (fe_b) flag_ev(1'b1, F_FRAME);
        if (pe_b) flag_ev(1'b1, F_PAR);
        if (ov_b) flag_ev(1'b1, F_OVR);
    end

    task automatic drive(input bit inst, input logic v, input int n);
        if (inst) rx_b = v; else rx_a = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit inst, input logic [7:0] d, input bit has_par, input bit par, input bit stop);
        drive(inst, 1'b0, DIV);
        for (int i = 0; i < 8; i++) drive(inst, d[i], DIV);
        if (has_par) drive(inst, par, DIV);
        drive(inst, stop, DIV);
        if (inst) rx_b = 1'b1; else rx_a = 1'b1;
    endtask

    task automatic pop(input bit inst);
        if (inst) if_b.rd_en = 1'b1; else if_a.rd_en = 1'b1;
        @(posedge clk);
        #1;
        if_a.rd_en = 1'b0;
        if_b.rd_en = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (busy_a == lvl) break;
            @(posedge clk);
            #1;
        end
        if (busy_a !== lvl) check("busy_wait", busy_a, lvl);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
        if_a.rd_en = 1'b0; if_b.rd_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_empty", if_a.empty, 1);
        check("rst_full", if_a.full, 0);
        check("rst_count", if_a.count, 0);
        check("rst_busy", busy_a, 0);
        check("rst_rd_data", if_a.rd_data, 0);
        check("rst_b_empty", if_b.empty, 1);
        rstn = 1'b1;
        drive(0, 1'b1, 4);

        // single 8N1 frame and its latency
        exp_a.push_back(8'h41);
        fork
            send(0, 8'h41, 0, 0, 1);
            begin
                wait_busy(1'b1, 20);
                wait_busy(1'b0, 3000);
                check("t1_empty_at_stop", if_a.empty, 1);
                @(posedge clk);
                #1;
                check("t1_empty_next", if_a.empty, 0);
                check("t1_rd_data", if_a.rd_data, 8'h41);
                check("t1_count", if_a.count, 1);
            end
        join
        pop(0);
        check("t1_empty_after_pop", if_a.empty, 1);

        // fill to full, then one overrun
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) exp_a.push_back(8'(i));
            else        fl_a.push_back(F_OVR);
            send(0, 8'(i), 0, 0, 1);
            if (i == 14) check("t2_not_full_15", if_a.full, 0);
            if (i == 15) check("t2_full_16", if_a.full, 1);
        end
        check("t2_count_after_ovr", if_a.count, 16);

        // push and pop together while full
        exp_a.push_back(8'h77);
        fork
            send(0, 8'h77, 0, 0, 1);
            begin
                wait_busy(1'b1, 20);
                wait_busy(1'b0, 3000);
                if_a.rd_en = 1'b1;
                @(posedge clk);
                #1;
                if_a.rd_en = 1'b0;
            end
        join
        check("t3_count", if_a.count, 16);
        check("t3_full", if_a.full, 1);
        for (int i = 0; i < 16; i++) pop(0);
        check("t3_empty", if_a.empty, 1);
        check("t3_count_zero", if_a.count, 0);

        // bad stop bit, long break, then a good frame
        fl_a.push_back(F_FRAME);
        send(0, 8'hA5, 0, 0, 0);
        drive(0, 1'b0, 30 * DIV);
        drive(0, 1'b1, DIV);
        exp_a.push_back(8'h5A);
        send(0, 8'h5A, 0, 0, 1);
        check("t4_count", if_a.count, 1);
        pop(0);
        check("t4_empty", if_a.empty, 1);

        // even parity: 0x03 needs parity bit 0
        fl_b.push_back(F_PAR);
        send(1, 8'h03, 1, 1, 1);
        check("t5_bad_par_count", if_b.count, 0);
        exp_b.push_back(8'h03);
        send(1, 8'h03, 1, 0, 1);
        check("t5_good_par_count", if_b.count, 1);
        pop(1);
        check("t5_b_empty", if_b.empty, 1);

        // short glitch is rejected
        drive(0, 1'b0, 100);
        drive(0, 1'b1, 3 * DIV);
        check("t6_glitch_busy", busy_a, 0);
        check("t6_glitch_count", if_a.count, 0);

        // reset mid-frame with entries held
        send(0, 8'h11, 0, 0, 1);
        send(0, 8'h22, 0, 0, 1);
        send(0, 8'h33, 0, 0, 1);
        check("t6_count3", if_a.count, 3);
        drive(0, 1'b0, DIV);
        drive(0, 1'b1, DIV);
        drive(0, 1'b0, 50);
        #5;
        rstn = 1'b0;
        #1;
        check("t6_rst_empty", if_a.empty, 1);
        check("t6_rst_count", if_a.count, 0);
        check("t6_rst_busy", busy_a, 0);
        check("t6_rst_rd_data", if_a.rd_data, 0);
        exp_a.delete();
        rx_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(0, 1'b1, 2 * DIV);
        check("t6_post_empty", if_a.empty, 1);
        check("t6_post_busy", busy_a, 0);

        check("left_exp_a", exp_a.size(), 0);
        check("left_exp_b", exp_b.size(), 0);
        check("left_flag_a", fl_a.size(), 0);
        check("left_flag_b", fl_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
